// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared state encoding and limits for d_input_debouncer
// Purpose: debounce FSM state enum and legal DEBOUNCE_CYCLES bounds.
// Ports: none (package).
package debounce_pkg;

  typedef enum logic [1:0] {
    ST_LO   = 2'd0,
    PEND_HI = 2'd1,
    ST_HI   = 2'd2,
    PEND_LO = 2'd3
  } deb_state_t;

  localparam int DEB_MIN_CYCLES = 1;
  localparam int DEB_MAX_CYCLES = 65535;

endpackage

// File: rtl/d_input_debouncer_sync_2ff.sv
// rtl/d_input_debouncer_sync_2ff.sv - 1-bit two-flop synchronizer
// Purpose: brings an asynchronous level into the clk domain.
// Ports:
//   clk   in  : capture clock
//   reset in  : asynchronous active-high, clears both flops to 0
//   d     in  : asynchronous level
//   q     out : synchronized level, two clk edges behind d
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/d_input_debouncer.sv
// rtl/d_input_debouncer.sv - consecutive-sample debouncer feeding a D flip-flop stage
// Purpose: turns a bouncy raw level into a clean registered level plus
//   one-cycle rise/fall pulses. Macro DEBOUNCE_SYNC_EN inserts a two-flop
//   synchronizer in front of the FSM (+2 cycles latency); without it din_raw
//   must already be synchronous to clk.
// Ports:
//   clk     in  : single clock, rising edge
//   reset   in  : asynchronous active-high
//   din_raw in  : raw level, may bounce
//   D       out : debounced level
//   rise    out : one-cycle pulse when D goes 0->1
//   fall    out : one-cycle pulse when D goes 1->0
//   pending out : a candidate level change is being counted
module d_input_debouncer
  import debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic din_raw,
  output logic D,
  output logic rise,
  output logic fall,
  output logic pending
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  generate
    if (DEBOUNCE_CYCLES < DEB_MIN_CYCLES || DEBOUNCE_CYCLES > DEB_MAX_CYCLES) begin : g_bad_cfg
      $error("d_input_debouncer: DEBOUNCE_CYCLES out of range");
    end
  endgenerate

  logic s;

`ifdef DEBOUNCE_SYNC_EN
  sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (din_raw),
    .q     (s)
  );
`else
  assign s = din_raw;
`endif

  deb_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             rise_nxt, fall_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_LO;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_LO: begin
        if (s) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_nxt = ST_HI;
          end else begin
            state_nxt = PEND_HI;
            cnt_nxt   = CNT_ONE;
          end
        end
      end
      PEND_HI: begin
        if (!s) begin
          state_nxt = ST_LO;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = ST_HI;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      ST_HI: begin
        if (!s) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_nxt = ST_LO;
          end else begin
            state_nxt = PEND_LO;
            cnt_nxt   = CNT_ONE;
          end
        end
      end
      PEND_LO: begin
        if (s) begin
          state_nxt = ST_HI;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = ST_LO;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      default: begin
        state_nxt = ST_LO;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Pulses only on a genuine level change: a rejected glitch (PEND_LO->ST_HI
  // or PEND_HI->ST_LO) leaves D unchanged and must not pulse.
  assign rise_nxt = (state_nxt == ST_HI) && (state == PEND_HI || state == ST_LO);
  assign fall_nxt = (state_nxt == ST_LO) && (state == PEND_LO || state == ST_HI);

  // Outputs are decoded from the next state and registered alongside it, so
  // they change on the same edge as the state and have no path from din_raw.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      D       <= 1'b0;
      rise    <= 1'b0;
      fall    <= 1'b0;
      pending <= 1'b0;
    end else begin
      D       <= (state_nxt == ST_HI) || (state_nxt == PEND_LO);
      rise    <= rise_nxt;
      fall    <= fall_nxt;
      pending <= (state_nxt == PEND_HI) || (state_nxt == PEND_LO);
    end
  end

endmodule

// File: tb/tb_d_input_debouncer.sv
// tb/tb_d_input_debouncer.sv - randomized run-length reference check of d_input_debouncer
module tb_d_input_debouncer;

`ifdef DEBOUNCE_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic din_raw;
  logic d0, r0, f0, p0;
  logic d1, r1, f1, p1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  d_input_debouncer #(.DEBOUNCE_CYCLES(4)) u_dut4 (
    .clk     (clk),
    .reset   (reset),
    .din_raw (din_raw),
    .D       (d0),
    .rise    (r0),
    .fall    (f0),
    .pending (p0)
  );

  d_input_debouncer #(.DEBOUNCE_CYCLES(1)) u_dut1 (
    .clk     (clk),
    .reset   (reset),
    .din_raw (din_raw),
    .D       (d1),
    .rise    (r1),
    .fall    (f1),
    .pending (p1)
  );

  int   m_n [2];
  logic m_lvl [2];
  int   m_run [2];
  logic m_rise [2];
  logic m_fall [2];
  logic hist [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic model_sample();
    if (hist.size() <= SYNC_LAT) return 1'b0;
    return hist[hist.size() - 1 - SYNC_LAT];
  endfunction

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < 2; i++) begin
      m_lvl[i]  = 1'b0;
      m_run[i]  = 0;
      m_rise[i] = 1'b0;
      m_fall[i] = 1'b0;
    end
  endtask

  // Accepted level flips once N consecutive samples disagree with it.
  task automatic model_step();
    logic smp;
    hist.push_back(din_raw);
    if (hist.size() > 8) void'(hist.pop_front());
    smp = model_sample();
    for (int i = 0; i < 2; i++) begin
      m_rise[i] = 1'b0;
      m_fall[i] = 1'b0;
      if (smp != m_lvl[i]) begin
        m_run[i]++;
        if (m_run[i] == m_n[i]) begin
          m_lvl[i] = smp;
          m_run[i] = 0;
          if (smp) m_rise[i] = 1'b1;
          else     m_fall[i] = 1'b1;
        end
      end else begin
        m_run[i] = 0;
      end
    end
  endtask

  task automatic check_outputs();
    chk("d_n4",       d0,      m_lvl[0]);
    chk("rise_n4",    r0,      m_rise[0]);
    chk("fall_n4",    f0,      m_fall[0]);
    chk("pending_n4", p0,      m_run[0] > 0);
    chk("both_n4",    r0 & f0, 1'b0);
    chk("d_n1",       d1,      m_lvl[1]);
    chk("rise_n1",    r1,      m_rise[1]);
    chk("fall_n1",    f1,      m_fall[1]);
    chk("pending_n1", p1,      m_run[1] > 0);
    chk("both_n1",    r1 & f1, 1'b0);
  endtask

  task automatic step(input logic v);
    @(negedge clk);
    check_outputs();
    din_raw = v;
    @(posedge clk);
    model_step();
  endtask

  initial begin
    m_n[0] = 4;
    m_n[1] = 1;
    reset   = 1'b1;
    din_raw = 1'b0;
    model_reset();
    repeat (2) begin
      @(negedge clk);
      check_outputs();
    end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    model_step();

    // quiet low input
    repeat (20) step(1'b0);

    // clean rise and hold
    repeat (12) step(1'b1);
    repeat (12) step(1'b0);

    // glitch during counting: 3 high, 1 low, then held high
    repeat (3) step(1'b1);
    step(1'b0);
    repeat (10) step(1'b1);
    repeat (12) step(1'b0);

    // toggle every 3 cycles
    for (int t = 0; t < 12; t++) begin
      repeat (3) step(t[0] ? 1'b0 : 1'b1);
    end
    repeat (12) step(1'b0);

    // reset in the middle of a falling count
    repeat (12) step(1'b1);
    repeat (2 + SYNC_LAT) step(1'b0);
    @(negedge clk);
    check_outputs();
    chk("pre_rst_pending_n4", p0, 1'b1);
    reset = 1'b1;
    #1;
    model_reset();
    chk("rst_d_n4",       d0, 1'b0);
    chk("rst_fall_n4",    f0, 1'b0);
    chk("rst_pending_n4", p0, 1'b0);
    chk("rst_d_n1",       d1, 1'b0);
    repeat (2) begin
      @(negedge clk);
      check_outputs();
    end
    @(negedge clk);
    reset   = 1'b0;
    din_raw = 1'b1;
    @(posedge clk);
    model_step();
    repeat (12) step(1'b1);

    // random bouncy stimulus
    for (int b = 0; b < 250; b++) begin
      logic v;
      int   len;
      v   = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 7);
      repeat (len) step(v);
    end

    @(negedge clk);
    check_outputs();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
